// File: rtl/eth_pkg.sv
// Shared Ethernet MAC definitions: framing constants, CRC-32 parameters,
// the RX state encoding and the bytewise CRC-32 update.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_DATA,
        RX_DROP
    } rx_state_t;

    // Reflected CRC-32: data enters LSB first, one byte per call.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        // NOTE: blocking assignments here are deliberate; each bit step feeds the next within one evaluation.
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// One-byte-per-cycle CRC-32 register with init and enable; shared by the
// MAC receive and transmit paths.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc32_next(crc, data);
        end
    end

endmodule

// File: rtl/eth_mac_rx.sv
// GMII receive engine: preamble/SFD detection, FCS check and strip, AXIS output.
// Statistics outputs are built only when ETH_MAC_RX_STATS_EN is defined.
module eth_mac_rx
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  m_axis_rx_tdata,
    output logic        m_axis_rx_tvalid,
    output logic        m_axis_rx_tlast,
    output logic        m_axis_rx_tuser,
    input  logic        m_axis_rx_tready,
    output logic        rx_busy,
    output logic [15:0] rx_frame_count,
    output logic [15:0] rx_error_count,
    output logic        rx_crc_error
);

    localparam int          DLY     = 5;
    localparam logic [10:0] DLY_LEN = 11'(DLY);
    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME);

    rx_state_t   state, state_next;
    logic        dv_q;
    logic [7:0]  dly [DLY];
    logic [10:0] len;
    logic        er_flag;
    logic        ovf_flag;
    logic [31:0] crc;

    logic byte_in, frame_end, full, crc_bad, len_bad, ovf_now;
    logic beat_load, beat_user;

    assign byte_in   = (state == RX_DATA) && gmii_rx_dv;
    assign frame_end = (state == RX_DATA) && !gmii_rx_dv;
    assign full      = (len >= DLY_LEN);
    assign crc_bad   = (crc != CRC32_RESIDUE);
    assign len_bad   = (len < MIN_LEN) || (len > MAX_LEN);
    assign ovf_now   = m_axis_rx_tvalid && !m_axis_rx_tready;
    assign beat_load = (byte_in || frame_end) && full;
    assign beat_user = crc_bad || er_flag || gmii_rx_er || len_bad || ovf_flag || ovf_now;
    assign rx_busy   = (state != RX_IDLE);

    eth_crc32 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (state != RX_DATA),
        .en   (byte_in),
        .data (gmii_rxd),
        .crc  (crc)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            RX_IDLE: begin
                if (gmii_rx_dv && !dv_q) begin
                    state_next = (gmii_rxd == ETH_PREAMBLE) ? RX_PREAMBLE : RX_DROP;
                end
            end
            RX_PREAMBLE: begin
                if (!gmii_rx_dv)                 state_next = RX_IDLE;
                else if (gmii_rxd == ETH_SFD)    state_next = RX_DATA;
                else if (gmii_rxd != ETH_PREAMBLE) state_next = RX_DROP;
            end
            RX_DATA: if (!gmii_rx_dv) state_next = RX_IDLE;
            RX_DROP: if (!gmii_rx_dv) state_next = RX_IDLE;
            default: state_next = RX_IDLE;
        endcase
    end

    // dv_q resets high so a dv already asserted at reset release is not taken as a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RX_IDLE;
            dv_q             <= 1'b1;
            len              <= '0;
            er_flag          <= 1'b0;
            ovf_flag         <= 1'b0;
            m_axis_rx_tdata  <= '0;
            m_axis_rx_tvalid <= 1'b0;
            m_axis_rx_tlast  <= 1'b0;
            m_axis_rx_tuser  <= 1'b0;
        end else begin
            state <= state_next;
            dv_q  <= gmii_rx_dv;

            if (state != RX_DATA) begin
                len      <= '0;
                er_flag  <= 1'b0;
                ovf_flag <= 1'b0;
            end else begin
                if (byte_in && len != '1) len <= len + 11'd1;
                if (gmii_rx_er)           er_flag <= 1'b1;
                if (beat_load && ovf_now) ovf_flag <= 1'b1;
            end

            if (beat_load) begin
                m_axis_rx_tdata  <= dly[DLY-1];
                m_axis_rx_tvalid <= 1'b1;
                m_axis_rx_tlast  <= frame_end;
                m_axis_rx_tuser  <= frame_end && beat_user;
            end else if (m_axis_rx_tready) begin
                m_axis_rx_tvalid <= 1'b0;
            end
        end
    end

    // NOTE: the delay line has no reset; clearing len marks it empty, so stale contents are never emitted.
    always_ff @(posedge clk) begin
        if (byte_in) begin
            dly[0] <= gmii_rxd;
            for (int i = 1; i < DLY; i++) dly[i] <= dly[i-1];
        end
    end

`ifdef ETH_MAC_RX_STATS_EN
    logic [15:0] frame_cnt, error_cnt;
    logic        crc_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            error_cnt <= '0;
            crc_pulse <= 1'b0;
        end else begin
            crc_pulse <= frame_end && full && crc_bad;
            if (frame_end) begin
                if (full && !beat_user) begin
                    if (frame_cnt != '1) frame_cnt <= frame_cnt + 16'd1;
                end else if (error_cnt != '1) begin
                    error_cnt <= error_cnt + 16'd1;
                end
            end
        end
    end

    assign rx_frame_count = frame_cnt;
    assign rx_error_count = error_cnt;
    assign rx_crc_error   = crc_pulse;
`else
    assign rx_frame_count = '0;
    assign rx_error_count = '0;
    assign rx_crc_error   = 1'b0;
`endif

endmodule

// File: tb/tb_eth_mac_rx.sv
// Scoreboard bench for eth_mac_rx: randomized frames, reference model built
// from frame-level rules, decoupled monitor on the AXIS output.
module tb_eth_mac_rx;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       lossy;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic        m_axis_rx_tready = 1'b1;
    logic [7:0]  m_axis_rx_tdata;
    logic        m_axis_rx_tvalid, m_axis_rx_tlast, m_axis_rx_tuser;
    logic        rx_busy, rx_crc_error;
    logic [15:0] rx_frame_count, rx_error_count;

    beat_t sb[$];
    beat_t mon_beat;
    int n_cmp = 0, n_bad = 0;
    int exp_good = 0, exp_err = 0, exp_crc = 0, seen_crc = 0;

    eth_mac_rx #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
        .clk              (clk),
        .rst              (rst),
        .gmii_rxd         (gmii_rxd),
        .gmii_rx_dv       (gmii_rx_dv),
        .gmii_rx_er       (gmii_rx_er),
        .m_axis_rx_tdata  (m_axis_rx_tdata),
        .m_axis_rx_tvalid (m_axis_rx_tvalid),
        .m_axis_rx_tlast  (m_axis_rx_tlast),
        .m_axis_rx_tuser  (m_axis_rx_tuser),
        .m_axis_rx_tready (m_axis_rx_tready),
        .rx_busy          (rx_busy),
        .rx_frame_count   (rx_frame_count),
        .rx_error_count   (rx_error_count),
        .rx_crc_error     (rx_crc_error)
    );

    always #4 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fcs(input byte_q_t b, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic byte_q_t add_fcs(input byte_q_t b);
        logic [31:0] f = ref_fcs(b, b.size());
        byte_q_t r = b;
        for (int k = 0; k < 4; k++) r.push_back(f[8*k +: 8]);
        return r;
    endfunction

    function automatic byte_q_t rand_payload(input int n);
        byte_q_t r;
        for (int i = 0; i < n; i++) r.push_back(8'($urandom));
        return r;
    endfunction

    // Frame-level expectation: N-4 beats, FCS stripped, tuser from the frame's faults.
    task automatic expect_frame(input byte_q_t fr, input bit er, input bit lossy);
        int n = fr.size();
        logic [31:0] f;
        bit crc_ok, bad;
        beat_t b;
        if (n <= 4) begin
            exp_err++;
            return;
        end
        f = ref_fcs(fr, n - 4);
        crc_ok = ({fr[n-1], fr[n-2], fr[n-3], fr[n-4]} == f);
        bad = !crc_ok || er || (n < 64) || (n > 1518) || lossy;
        for (int i = 0; i < n - 4; i++) begin
            b.data  = fr[i];
            b.last  = (i == n - 5);
            b.user  = bad;
            b.lossy = lossy;
            sb.push_back(b);
        end
        if (bad) exp_err++; else exp_good++;
        if (!crc_ok) exp_crc++;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && m_axis_rx_tvalid && m_axis_rx_tready) begin
            // Frames under backpressure lose beats: skip expected entries the sink never saw.
            while (sb.size() > 0 && sb[0].lossy && !sb[0].last &&
                   (m_axis_rx_tlast || sb[0].data != m_axis_rx_tdata))
                void'(sb.pop_front());
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat",
                         m_axis_rx_tdata, m_axis_rx_tlast);
            end else begin
                mon_beat = sb.pop_front();
                check("beat_data", 32'(m_axis_rx_tdata), 32'(mon_beat.data));
                check("beat_last", 32'(m_axis_rx_tlast), 32'(mon_beat.last));
                if (mon_beat.last) check("beat_user", 32'(m_axis_rx_tuser), 32'(mon_beat.user));
            end
        end
        if (!rst && rx_crc_error) begin
            seen_crc++;
            check("crc_pulse_on_tlast", {30'h0, m_axis_rx_tvalid, m_axis_rx_tlast}, 32'h3);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic dv, input logic [7:0] d, input logic er);
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        gmii_rx_er = er;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
`ifdef ETH_MAC_RX_STATS_EN
        check({tag, "_frame_count"}, 32'(rx_frame_count), 32'(exp_good));
        check({tag, "_error_count"}, 32'(rx_error_count), 32'(exp_err));
`else
        check({tag, "_frame_count"}, 32'(rx_frame_count), 32'h0);
        check({tag, "_error_count"}, 32'(rx_error_count), 32'h0);
`endif
    endtask

    task automatic send_frame(input string tag, input byte_q_t fr, input int pre_len,
                              input int er_at, input int bp_at);
        expect_frame(fr, (er_at >= 0) && (er_at < fr.size()), bp_at >= 0);
        for (int i = 0; i < pre_len; i++) cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < fr.size(); i++) begin
            m_axis_rx_tready = !((bp_at >= 0) && (i >= bp_at) && (i < bp_at + 3));
            cyc(1'b1, fr[i], i == er_at);
        end
        m_axis_rx_tready = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        if (fr.size() > 4)
            check({tag, "_tlast_latency"}, {30'h0, m_axis_rx_tvalid, m_axis_rx_tlast}, 32'h3);
        repeat (12) cyc(1'b0, 8'h00, 1'b0);
        check({tag, "_idle_busy"}, 32'(rx_busy), 32'h0);
        check_counts(tag);
    endtask

    initial begin
        byte_q_t p, fr;

        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        check("reset_tvalid", 32'(m_axis_rx_tvalid), 32'h0);
        check("reset_tlast",  32'(m_axis_rx_tlast),  32'h0);
        check("reset_tuser",  32'(m_axis_rx_tuser),  32'h0);
        check("reset_busy",   32'(rx_busy),          32'h0);
        check("reset_crcerr", 32'(rx_crc_error),     32'h0);
        check_counts("reset");
        rst = 1'b0;
        repeat (3) cyc(1'b0, 8'h00, 1'b0);

        // Good 64-byte frame with an incrementing payload.
        p.delete();
        for (int i = 0; i < 60; i++) p.push_back(8'(i));
        fr = add_fcs(p);
        send_frame("good64", fr, 7, -1, -1);

        fr[63] = fr[63] ^ 8'h01;
        send_frame("badfcs", fr, 7, -1, -1);

        fr = add_fcs(rand_payload(60));
        send_frame("rx_er", fr, 7, 20, -1);

        fr = add_fcs(rand_payload(36));
        send_frame("runt40", fr, 7, -1, -1);

        fr = rand_payload(3);
        send_frame("short3", fr, 7, -1, -1);

        // Preamble corrupted by a non-0x55/0xD5 byte: dropped, nothing counted.
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h12, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom), 1'b0);
        check("drop_busy", 32'(rx_busy), 32'h1);
        repeat (12) cyc(1'b0, 8'h00, 1'b0);
        check("drop_idle_busy", 32'(rx_busy), 32'h0);
        check_counts("drop");

        fr = add_fcs(rand_payload(1514));
        send_frame("max1518", fr, 7, -1, -1);

        fr = add_fcs(rand_payload(1515));
        send_frame("long1519", fr, 7, -1, -1);

        fr = add_fcs(rand_payload(60));
        send_frame("backpressure", fr, 7, -1, 10);

        // Reset mid-frame with dv held high: the frame is discarded without tlast.
        fr = add_fcs(rand_payload(60));
        expect_frame(fr, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) cyc(1'b1, fr[i], 1'b0);
        rst = 1'b1;
        cyc(1'b1, fr[30], 1'b0);
        check("midrst_tvalid", 32'(m_axis_rx_tvalid), 32'h0);
        check("midrst_tlast",  32'(m_axis_rx_tlast),  32'h0);
        check("midrst_busy",   32'(rx_busy),          32'h0);
        rst = 1'b0;
        sb.delete();
        exp_good = 0;
        exp_err  = 0;
        exp_crc  = 0;
        seen_crc = 0;
        check_counts("midrst");
        for (int i = 31; i < 45; i++) cyc(1'b1, fr[i], 1'b0);
        check("midrst_dv_ignored", 32'(rx_busy), 32'h0);
        repeat (12) cyc(1'b0, 8'h00, 1'b0);

        fr = add_fcs(rand_payload(60));
        send_frame("after_rst", fr, 7, -1, -1);

        // Randomized mix of lengths, FCS corruption and rx_er.
        for (int k = 0; k < 8; k++) begin
            int n, er_at;
            n  = $urandom_range(1, 126);
            fr = add_fcs(rand_payload(n));
            if ($urandom_range(0, 3) == 0) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'(1 << $urandom_range(0, 7));
            er_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, fr.size() - 1)) : -1;
            send_frame("random", fr, $urandom_range(1, 7), er_at, -1);
        end

        repeat (20) cyc(1'b0, 8'h00, 1'b0);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
`ifdef ETH_MAC_RX_STATS_EN
        check("crc_pulse_total", 32'(seen_crc), 32'(exp_crc));
`else
        check("crc_pulse_total", 32'(seen_crc), 32'h0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eth_mac_rx.md
# eth_mac_rx

GMII receive-path engine for the Ethernet MAC. It sits between the PHY-side GMII receive pins and the RX AXI-Stream master toward user logic. It detects preamble and SFD, checks FCS with CRC-32, strips the FCS, and emits each frame byte-serially with `tlast` and a bad-frame `tuser` flag. It also maintains receive statistics.

## Interface
Reset is synchronous and active-high; the block has a single clock.

Parameters:
- MIN_FRAME, 64: minimum legal length in bytes, DA through FCS inclusive.
- MAX_FRAME, 1518: maximum legal length in bytes, DA through FCS inclusive.

Ports:
- clk  in  1  system clock, 125 MHz GMII RX clock domain
- rst  in  1  synchronous active-high reset
- gmii_rxd  in  8  receive data
- gmii_rx_dv  in  1  receive data valid
- gmii_rx_er  in  1  receive error
- m_axis_rx_tdata  out  8  payload byte
- m_axis_rx_tvalid  out  1  byte valid
- m_axis_rx_tlast  out  1  last payload byte of frame
- m_axis_rx_tuser  out  1  frame bad; meaningful only with tlast
- m_axis_rx_tready  in  1  sink ready
- rx_busy  out  1  high in every state except IDLE
- rx_frame_count  out  16  good frames received, saturating
- rx_error_count  out  16  bad frames received, saturating
- rx_crc_error  out  1  one-cycle pulse, coincident with the tlast beat of an FCS-failing frame

## Operation
- All outputs reset to 0, except rx_busy, which reset drives 0 via IDLE. Reset empties the delay line, clears the length counter and all sticky flags, and returns the FSM to IDLE. Reset applied mid-frame discards that frame without emitting tlast.
- FSM states and transitions:
  - IDLE: on a rising edge of dv (registered dv_q=0, dv=1) with rxd=0x55, go to PREAMBLE. On a dv rising edge with any other rxd, go to DROP. If dv is already high when leaving reset, the block ignores it until dv falls.
  - PREAMBLE: rxd=0x55 stays in PREAMBLE; rxd=0xD5 goes to DATA; any other byte goes to DROP; dv low returns to IDLE without counting.
  - DATA: each sampled byte enters the CRC and a 5-byte delay line, and increments an 11-bit length counter that saturates at 2047. On dv low, end-of-frame processing runs and the FSM goes to IDLE.
  - DROP: waits for dv low, then returns to IDLE. DROP counts nothing.
- Delay line behaviour:
  - Once 5 bytes are held, each new byte pushes the oldest one out to the AXIS register.
  - At end of frame, the 4 youngest bytes are the FCS and are discarded. The 5th-youngest byte is emitted with tlast=1.
- CRC rules: reflected CRC-32, polynomial 0xEDB88320, initialised to 0xFFFFFFFF, computed over DA through FCS. The frame passes if the register equals the residue 0xDEBB20E3.
- tuser at tlast is the OR of:
  - CRC failure
  - any rx_er sampled in DATA
  - length < MIN_FRAME
  - length > MAX_FRAME
  - overflow
- A frame of 4 or fewer bytes after SFD emits nothing and increments rx_error_count.
- Backpressure: GMII cannot stall, so a new beat overwrites the AXIS register while tvalid && !tready. Data is lost and the sticky overflow flag sets. tlast/tuser are never lost.
- Counters: rx_frame_count increments on tlast with tuser=0. rx_error_count increments on tlast with tuser=1, and on frames of 4 or fewer bytes.

## Timing
- Latency: byte k is sampled at edge t_k and presented on AXIS in the cycle after edge t_(k+5). The tlast beat is presented in the cycle after the edge that first samples dv low.
- tvalid clears on a handshake (tvalid && tready) unless a new beat loads in the same cycle.
- rx_crc_error and the counter updates occur in the same cycle that the tlast beat is loaded.
- Back-to-back frames: the minimum 12-byte IPG plus the 8-byte preamble always exceeds the 1-cycle end-of-frame processing, so no frame is lost between frames.

## Configuration
- ETH_MAC_RX_STATS_EN:
  - Defined: rx_frame_count, rx_error_count and rx_crc_error function as above.
  - Undefined: the counters and pulse logic are not compiled and the three outputs are tied to 0. Data path and tuser are unchanged.

## Structure
- Shared package eth_pkg holds:
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3
  - the RX state enum typedef
- Sub-module eth_crc32 is a one-byte-per-cycle CRC update with init/enable inputs. The TX path reuses it.

## Test plan
- Good frame: 7×0x55, 0xD5, bytes 0x00..0x3B, valid FCS (64 bytes) → 60 beats 0x00..0x3B, tlast on 0x3B, tuser=0, rx_frame_count=1, no crc pulse.
- Corrupted FCS: same frame with the last FCS byte XOR 0x01 → 60 beats, tuser=1, rx_crc_error pulse, rx_error_count=1.
- Error, length and abort cases:
  - gmii_rx_er high for 1 cycle at byte 20 → tuser=1.
  - 40-byte frame with valid FCS → 36 beats, tuser=1 (runt).
  - 3-byte frame → no beats, rx_error_count+1.
  - Preamble 0x55,0x55,0x12 → DROP, no counts.
- Max frame: 1518-byte valid frame → 1514 beats, tuser=0. 1519-byte valid frame → tuser=1.
- Backpressure: tready low for cycles 10–12 of a 64-byte frame → tuser=1 at tlast, tlast still delivered, frame not counted good.
- Reset mid-frame: rst asserted at byte 30 while dv stays high → outputs 0 immediately, no tlast. The next frame after dv falls is received correctly with rx_frame_count=1.
